uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8: number of data bits per frame, range 5..8.
REQ-002 Parameter OVERSAMPLE, default 16: rxclk_en ticks per bit period; fixed at 16 in this revision.
REQ-003 The clock and reset SHALL be one clock, clk_50m, with reset rst, synchronous and active-high.
REQ-004 clk_50m  input  1  system clock, 50 MHz.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 rxclk_en  input  1  single-cycle 16x-oversample tick from the baud generator.
REQ-007 rx  input  1  asynchronous serial line; idles high.
REQ-008 rdy_clr  input  1  single-cycle acknowledge; clears rdy and overrun.
REQ-009 data  output  DATA_BITS  last correctly framed byte, LSB first on the line.
REQ-010 rdy  output  1  a new byte is valid in data.
REQ-011 frame_err  output  1  stop bit was sampled low; sticky.
REQ-012 overrun  output  1  a byte completed while rdy was already high; sticky.
REQ-013 parity_err  output  1  exists only with UART_RX_PARITY_EN; parity mismatch; sticky.

Function
REQ-014 rx SHALL pass through a two-flop synchronizer, preset to 1, before any use.
REQ-015 FSM states: IDLE, START, DATA, PARITY (only with macro), STOP. A 4-bit sample counter and a bit counter advance only on rxclk_en.
REQ-016 IDLE: on a tick with synced rx = 0, go to START and set counter to 0.
REQ-017 START: on the tick where counter = 7 (mid-bit), synced rx = 0 moves to DATA with counter 0; synced rx = 1 is a glitch and returns to IDLE with no flag.
REQ-018 DATA: on every tick where counter = 15, shift synced rx into the MSB of the shift register (LSB-first reception) and wrap the counter to 0. After DATA_BITS samples, go to PARITY if enabled, else STOP.
REQ-019 STOP: on the tick where counter = 15, sample the stop bit, then return to IDLE immediately. Returning at mid-stop-bit supports back-to-back frames.
REQ-020 Stop bit = 1: data is loaded from the shift register and rdy is set on the next clk_50m edge. Latency is one clock after the stop-sample tick.
REQ-021 Stop bit = 0: frame_err is set, and data and rdy are unchanged.
REQ-022 A good frame completing while rdy = 1 SHALL overwrite data and set overrun.
REQ-023 rdy_clr in the same cycle as a rdy set: the set wins, and overrun evaluates against the old rdy.
REQ-024 rdy_clr clears rdy and overrun only. frame_err and parity_err clear only on a good frame or on reset.
REQ-025 When rxclk_en = 0, no state, counter or output SHALL change, except for the rdy_clr effects.

Reset
REQ-026 rst SHALL force the following on the next edge, overriding all other inputs: state = IDLE, counters = 0, synchronizer = 11, data = 0, rdy = 0, frame_err = 0, overrun = 0, parity_err = 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame. Reception restarts at the next falling edge after reset deasserts.

Configuration
REQ-028 Macro UART_RX_PARITY_EN.
- Defined: a PARITY state follows DATA and samples one even-parity bit at counter = 15. A mismatch sets parity_err and suppresses rdy and the data update; frame_err is still evaluated.
- Undefined: no PARITY state, no parity_err port, and the frame is 8N1.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state encodings, OVERSAMPLE, MID_SAMPLE (7) and LAST_SAMPLE (15), shared with the future uart_tx.
REQ-030 One sub-module, sync2 (a two-flop synchronizer with preset value), is instantiated for rx. All other logic is flat in uart_rx.

Verification
REQ-031 Setup for all scenarios: rxclk_en pulses once every 27 clocks (115200 baud x 16); one bit = 432 clocks.
REQ-032 Frame 0xA5 in 8N1 -> rdy = 1 with data = 0xA5 exactly 1 clock after the stop-sample tick; frame_err = 0.
REQ-033 A 3-tick low glitch on an idle rx -> FSM returns to IDLE; rdy, frame_err and data stay unchanged.
REQ-034 Frame 0x3C with the stop bit held low -> frame_err = 1, rdy = 0, data keeps its old value. A following good frame 0x11 -> frame_err = 0, data = 0x11.
REQ-035 Back-to-back frames 0x01 then 0x02 with no rdy_clr -> data = 0x02 and overrun = 1. rdy_clr pulsed on the same cycle as the second rdy set -> rdy = 1.
REQ-036 rst pulsed at bit 4 of frame 0xFF -> all outputs 0; the next frame 0x5A is received correctly.
REQ-037 With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 (wrong) -> parity_err = 1, rdy = 0. The same frame with parity bit 1 -> rdy = 1, data = 0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and oversampling constants.
// Used by uart_rx now and by uart_tx later.
// UART_RX_PARITY_EN adds the PARITY state encoding.
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int MID_SAMPLE  = 7;   // start bit is checked at its middle
  localparam int LAST_SAMPLE = 15;  // data, parity and stop bits are sampled here

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle of the UART receiver (everything except clock and reset).
// master: baud tick, serial line and acknowledge out; received byte and flags in.
// slave : the receiver side. UART_RX_PARITY_EN adds parity_err.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rxclk_en;   // 16x oversample tick
  logic                 rx;         // serial line, idles high
  logic                 rdy_clr;    // acknowledge: clears rdy and overrun
  logic [DATA_BITS-1:0] data;       // last correctly framed byte
  logic                 rdy;        // new byte valid in data
  logic                 frame_err;  // stop bit sampled low, sticky
  logic                 overrun;    // byte completed while rdy high, sticky
`ifdef UART_RX_PARITY_EN
  logic                 parity_err; // even-parity mismatch, sticky

  modport master (output rxclk_en, rx, rdy_clr,
                  input  data, rdy, frame_err, overrun, parity_err);
  modport slave  (input  rxclk_en, rx, rdy_clr,
                  output data, rdy, frame_err, overrun, parity_err);
`else
  modport master (output rxclk_en, rx, rdy_clr,
                  input  data, rdy, frame_err, overrun);
  modport slave  (input  rxclk_en, rx, rdy_clr,
                  output data, rdy, frame_err, overrun);
`endif
endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer with a configurable reset value.
// Latency: two clk_i edges. No backpressure.
// Ports: clk_i, rst_i (sync, active-high), d_i async input, q_o synchronized output.
module sync2 #(
  parameter logic PRESET = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) ff_q <= {2{PRESET}};
    else        ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, LSB first, 16x oversampled; 8N1 by default, even parity with UART_RX_PARITY_EN.
// Latency: rdy/data update one clk_50m edge after the stop-bit sample tick.
// Backpressure: none; an unacknowledged byte is overwritten and flagged by overrun.
// Ports: clk_50m, rst (sync, active-high), bus (uart_rx_if.slave: rxclk_en, rx, rdy_clr in;
//        data, rdy, frame_err, overrun[, parity_err] out).
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input logic      clk_50m,
  input logic      rst,
  uart_rx_if.slave bus
);
  import uart_pkg::*;

  localparam int               CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID_SAMPLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_SAMPLE);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rdy_q, rdy_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 frame_ok;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 pbad_q, pbad_d;   // parity mismatch of the frame in flight
`endif

  sync2 #(.PRESET(1'b1)) u_sync_rx (
    .clk_i (clk_50m),
    .rst_i (rst),
    .d_i   (bus.rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pbad_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
      pbad_q  <= pbad_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    rdy_d    = rdy_q;
    ferr_d   = ferr_q;
    ovr_d    = ovr_q;
    frame_ok = rx_s;
`ifdef UART_RX_PARITY_EN
    perr_d   = perr_q;
    pbad_d   = pbad_q;
    frame_ok = rx_s & ~pbad_q;
`endif

    // The acknowledge acts on every clock; a completing frame below overrides it.
    if (bus.rdy_clr) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end

    if (bus.rxclk_en) begin
      cnt_d = cnt_q + 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          bit_d = '0;
          if (!rx_s) state_d = ST_START;
        end
        ST_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_d   = '0;
            // A line back high at mid-start was only a glitch.
            state_d = rx_s ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            pbad_d  = rx_s ^ (^shift_q);   // even parity: all bits XOR to 0
            state_d = ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          // Leaving at mid-stop lets the next start edge be caught in IDLE.
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            if (!rx_s) ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            if (pbad_q) perr_d = 1'b1;
`endif
            if (frame_ok) begin
              data_d = shift_q;
              rdy_d  = 1'b1;
              ovr_d  = ovr_d | rdy_q;      // judged against rdy before this edge
              ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
              perr_d = 1'b0;
`endif
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.rdy       = rdy_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int DB  = 8;
  localparam int BIT = 432;   // clocks per bit at 27 clocks per tick
  localparam int GAP = 400;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  // Behavioural reference state, updated from the frame-level rules.
  logic [7:0] m_data;
  logic       m_rdy, m_ferr, m_ovr, m_perr;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(.DATA_BITS(DB)) dut (
    .clk_50m (clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Baud tick: high during the cycle that ends on every posedge whose index is a multiple of 27.
  initial begin
    bus.rxclk_en = 1'b0;
    forever begin
      @(negedge clk);
      bus.rxclk_en = ((cyc + 1) % 27 == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"},      32'(bus.data),      32'(m_data));
    check({tag, ".rdy"},       32'(bus.rdy),       32'(m_rdy));
    check({tag, ".frame_err"}, 32'(bus.frame_err), 32'(m_ferr));
    check({tag, ".overrun"},   32'(bus.overrun),   32'(m_ovr));
`ifdef UART_RX_PARITY_EN
    check({tag, ".parity_err"}, 32'(bus.parity_err), 32'(m_perr));
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx      = 1'b1;
      bus.rdy_clr = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.rdy_clr = 1'b1;
    @(negedge clk);
    bus.rdy_clr = 1'b0;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
  endtask

  // Sends one frame. The stop-sample tick is predicted from the start edge:
  // first tick seeing the synchronized low, +8 ticks to mid-start, +16 per later bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic par_flip, input logic clr_at_set);
    logic [11:0] bits;
    int          nb;
    int          fall;
    int          st;
    int          stop_cyc;
    logic        good;
    logic        old_rdy;
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) bits[1 + i] = b[i];
`ifdef UART_RX_PARITY_EN
    bits[DB + 1] = (^b) ^ par_flip;
    good = stop_bit & ~par_flip;
`else
    good = stop_bit;
`endif
    nb = DB + PAR + 2;
    bits[nb - 1] = stop_bit;

    @(negedge clk);
    fall     = cyc;
    st       = ((fall + 3 + 26) / 27) * 27;
    stop_cyc = st + 27 * (8 + 16 * (nb - 1));
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < BIT; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        bus.rx      = bits[k];
        bus.rdy_clr = clr_at_set && (cyc == stop_cyc - 1);
        if (cyc == stop_cyc - 1) check("pre_stop.rdy", 32'(bus.rdy), 32'(m_rdy));
        if (cyc == stop_cyc) begin
          old_rdy = m_rdy;
          if (clr_at_set) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
          end
          if (good) begin
            m_ovr  = m_ovr | old_rdy;
            m_rdy  = 1'b1;
            m_data = b;
            m_ferr = 1'b0;
            m_perr = 1'b0;
          end else begin
            if (!stop_bit) m_ferr = 1'b1;
            if (PAR == 1 && par_flip) m_perr = 1'b1;
          end
          check_all("post_stop");
        end
      end
    end
    bus.rdy_clr = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst         = 1'b1;
    bus.rx      = 1'b1;
    bus.rdy_clr = 1'b0;
    m_data = '0;
    m_rdy  = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    m_perr = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    idle(100);

    // Basic good frame with exact rdy latency.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(GAP);
    check_all("a5");

    // Three-tick low glitch: no flags, no data change.
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (81) @(negedge clk);
    bus.rx = 1'b1;
    idle(GAP);
    check_all("glitch");

    // Stop bit low, then a good frame clears the sticky flag.
    pulse_clr();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(GAP);
    check_all("stop_low");
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    idle(GAP);
    check_all("after_ferr");

    // Back-to-back frames; acknowledge lands on the second set.
    send_frame(8'h01, 1'b1, 1'b0, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0, 1'b1);
    idle(GAP);
    check_all("b2b");

    // Reset in the middle of bit 4 of 0xFF, then a clean frame.
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (BIT) @(negedge clk);
    bus.rx = 1'b1;
    repeat (4 * BIT + 200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_data = '0;
    m_rdy  = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    m_perr = 1'b0;
    check_all("mid_rst");
    idle(232 + (3 + PAR + 1) * BIT + GAP);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    idle(GAP);
    check_all("after_rst");

    pulse_clr();
    check_all("clr");

    for (int n = 0; n < 4; n++) begin
      if ($urandom_range(0, 1) == 1) pulse_clr();
      send_frame(8'($urandom), ($urandom_range(0, 3) != 0), 1'b0, ($urandom_range(0, 3) == 0));
      idle(GAP);
      check_all("rand");
    end

`ifdef UART_RX_PARITY_EN
    pulse_clr();
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    idle(GAP);
    check_all("par_bad");
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    idle(GAP);
    check_all("par_good");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
